// File: rtl/voting_pkg.sv
// voting_pkg: shared FSM state type, default widths and width helper for the vote verifier.
package voting_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, RESP, LOCK} state_e;
  localparam int DIGEST_W_DEF = 128;
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/voter_table.sv
// voter_table: enrollment digests with valid and voted bits, one indexed compare port.
module voter_table import voting_pkg::*; #(
  parameter int NUM_VOTERS = 3,
  parameter int DIGEST_W   = DIGEST_W_DEF,
  parameter int IDX_W      = clog2_min1(NUM_VOTERS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DIGEST_W-1:0]   wr_digest,
  input  logic [IDX_W-1:0]      rd_idx,
  input  logic [DIGEST_W-1:0]   cmp_digest,
  output logic                  rd_match,
  output logic                  rd_voted,
  input  logic                  set_voted,
  input  logic                  clr_voted,
  output logic [NUM_VOTERS-1:0] voted_mask
);
  logic [DIGEST_W-1:0]   mem_q [NUM_VOTERS];
  logic [NUM_VOTERS-1:0] valid_q, valid_d, voted_q, voted_d;
  logic                  wr_ok;
  assign wr_ok      = wr_en && (int'(wr_idx) < NUM_VOTERS);
  assign rd_match   = valid_q[rd_idx] && (mem_q[rd_idx] == cmp_digest);
  assign rd_voted   = voted_q[rd_idx];
  assign voted_mask = voted_q;
  // Re-enrolling an entry forgets its vote, so a replaced voter may vote again.
  always_comb begin
    valid_d = valid_q;
    voted_d = clr_voted ? '0 : voted_q;
    if (set_voted) voted_d[rd_idx] = 1'b1;
    if (wr_ok) begin
      valid_d[wr_idx] = 1'b1;
      voted_d[wr_idx] = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      voted_q <= '0;
    end else begin
      valid_q <= valid_d;
      voted_q <= voted_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_idx] <= wr_digest;
  end
endmodule

// File: rtl/voter_auth_ctrl.sv
// voter_auth_ctrl: sequential digest scan, one-vote-per-voter grant and failed-attempt lockout.
module voter_auth_ctrl import voting_pkg::*; #(
  parameter int NUM_VOTERS  = 3,
  parameter int DIGEST_W    = DIGEST_W_DEF,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   req_valid,
  input  logic [DIGEST_W-1:0]                    req_digest,
  output logic                                   req_ready,
  input  logic                                   enroll_we,
  input  logic [clog2_min1(NUM_VOTERS)-1:0]      enroll_idx,
  input  logic [DIGEST_W-1:0]                    enroll_digest,
  input  logic                                   clear_voted,
  output logic                                   resp_valid,
  output logic                                   success,
  output logic                                   access,
  output logic [clog2_min1(NUM_VOTERS)-1:0]      voter_idx,
  output logic                                   locked,
  output logic [clog2_min1(MAX_FAIL+1)-1:0]      fail_count,
  output logic [NUM_VOTERS-1:0]                  voted_mask
);
  localparam int IDX_W = clog2_min1(NUM_VOTERS);
  localparam int FC_W  = clog2_min1(MAX_FAIL + 1);
  localparam int LC_W  = clog2_min1(LOCK_CYCLES);
  state_e              state_q, state_d;
  logic [DIGEST_W-1:0] digest_q;
  logic [IDX_W-1:0]    idx_q, vidx_q;
  logic [FC_W-1:0]     fc_q;
  logic [LC_W-1:0]     lcnt_q;
  logic                success_q, access_q;
  logic                accept, match, rd_voted, scan_done, lock_done, fc_max;
  assign req_ready  = !rst && state_q == IDLE && !enroll_we;
  assign accept     = req_valid && req_ready;
  assign scan_done  = state_q == SCAN && (match || idx_q == IDX_W'(NUM_VOTERS - 1));
  assign lock_done  = state_q == LOCK && lcnt_q == LC_W'(LOCK_CYCLES - 1);
  assign fc_max     = fc_q == FC_W'(MAX_FAIL);
  assign resp_valid = state_q == RESP;
  assign locked     = state_q == LOCK;
  assign success    = success_q;
  assign access     = access_q;
  assign voter_idx  = vidx_q;
  assign fail_count = fc_q;
  voter_table #(.NUM_VOTERS(NUM_VOTERS), .DIGEST_W(DIGEST_W), .IDX_W(IDX_W)) u_table (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (enroll_we && state_q == IDLE),
    .wr_idx     (enroll_idx),
    .wr_digest  (enroll_digest),
    .rd_idx     (idx_q),
    .cmp_digest (digest_q),
    .rd_match   (match),
    .rd_voted   (rd_voted),
    .set_voted  (scan_done && match),
    .clr_voted  (clear_voted && (state_q == IDLE || state_q == LOCK)),
    .voted_mask (voted_mask)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? SCAN : IDLE;
      SCAN:    state_d = scan_done ? RESP : SCAN;
      RESP:    state_d = fc_max ? LOCK : IDLE;
      default: state_d = lock_done ? IDLE : LOCK;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      digest_q  <= '0;
      idx_q     <= '0;
      vidx_q    <= '0;
      fc_q      <= '0;
      lcnt_q    <= '0;
      success_q <= 1'b0;
      access_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        digest_q <= req_digest;
        idx_q    <= '0;
      end
      if (state_q == SCAN && !scan_done) idx_q <= idx_q + 1'b1;
      // Result registers update at scan end so they are valid throughout RESP.
      if (scan_done) begin
        success_q <= match;
        access_q  <= match && !rd_voted;
        vidx_q    <= match ? idx_q : '0;
        fc_q      <= match ? '0 : (fc_max ? fc_q : fc_q + 1'b1);
      end
      if (state_q == RESP) lcnt_q <= '0;
      if (state_q == LOCK) lcnt_q <= lcnt_q + 1'b1;
      if (lock_done) fc_q <= '0;
    end
  end
endmodule

// File: tb/tb_voter_auth_ctrl.sv
// tb_voter_auth_ctrl: directed checks of enrollment, hit/duplicate/miss, lockout and async reset.
module tb_voter_auth_ctrl;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic [127:0] req_digest = '0;
  logic         req_ready;
  logic         enroll_we = 1'b0;
  logic [1:0]   enroll_idx = '0;
  logic [127:0] enroll_digest = '0;
  logic         clear_voted = 1'b0;
  logic         resp_valid, success, access, locked;
  logic [1:0]   voter_idx, fail_count;
  logic [2:0]   voted_mask;
  int           tests = 0;
  int           fails = 0;
  localparam logic [127:0] D0 = {16{8'hA5}};
  localparam logic [127:0] D2 = {16{8'h3C}};
  localparam logic [127:0] DX = 128'h1;
  voter_auth_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_digest(req_digest), .req_ready(req_ready),
    .enroll_we(enroll_we), .enroll_idx(enroll_idx), .enroll_digest(enroll_digest),
    .clear_voted(clear_voted), .resp_valid(resp_valid), .success(success), .access(access),
    .voter_idx(voter_idx), .locked(locked), .fail_count(fail_count), .voted_mask(voted_mask)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic enroll(input logic [1:0] idx, input logic [127:0] d);
    enroll_we = 1'b1; enroll_idx = idx; enroll_digest = d;
    step();
    enroll_we = 1'b0;
  endtask
  task automatic req(input string tag, input logic [127:0] d, input int k, input logic s, input logic a,
                     input logic [1:0] vi, input logic [1:0] fc);
    int n;
    req_valid = 1'b1; req_digest = d;
    #1;
    n = 0;
    while (!req_ready && n < 50) begin step(); n++; end
    chk({tag, "_ready"}, req_ready, 1'b1);
    step();
    req_valid = 1'b0; req_digest = '0;
    n = 1;
    while (!resp_valid && n < 30) begin step(); n++; end
    chk({tag, "_lat"}, n, k + 1);
    chk({tag, "_success"}, success, s);
    chk({tag, "_access"}, access, a);
    chk({tag, "_idx"}, voter_idx, vi);
    chk({tag, "_fc"}, fail_count, fc);
    step();
    chk({tag, "_pulse"}, resp_valid, 1'b0);
  endtask
  initial begin
    int cnt;
    #12;
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_outs", {resp_valid, success, access, voter_idx, locked, fail_count, voted_mask}, '0);
    rst = 1'b0;
    step();
    chk("idle_ready", req_ready, 1'b1);
    enroll(2'd0, D0);
    enroll(2'd2, D2);
    req("d2_hit", D2, 3, 1'b1, 1'b1, 2'd2, 2'd0);
    chk("d2_mask", voted_mask, 3'b100);
    req("d2_dup", D2, 3, 1'b1, 1'b0, 2'd2, 2'd0);
    chk("dup_mask", voted_mask, 3'b100);
    req("miss1", DX, 3, 1'b0, 1'b0, 2'd0, 2'd1);
    req("miss2", DX, 3, 1'b0, 1'b0, 2'd0, 2'd2);
    req("miss3", DX, 3, 1'b0, 1'b0, 2'd0, 2'd3);
    chk("lock_on", locked, 1'b1);
    cnt = 0;
    while (locked && !req_ready && cnt < 40) begin cnt++; step(); end
    chk("lock_len", cnt, 16);
    chk("lock_fc", fail_count, 2'd0);
    chk("lock_ready", req_ready, 1'b1);
    req("m_a", DX, 3, 1'b0, 1'b0, 2'd0, 2'd1);
    req("m_b", DX, 3, 1'b0, 1'b0, 2'd0, 2'd2);
    req("d0_hit", D0, 1, 1'b1, 1'b1, 2'd0, 2'd0);
    chk("no_lock", locked, 1'b0);
    chk("d0_mask", voted_mask, 3'b101);
    enroll_we = 1'b1; enroll_idx = 2'd2; enroll_digest = D2;
    req_valid = 1'b1; req_digest = D2;
    #1;
    chk("enr_block", req_ready, 1'b0);
    step();
    enroll_we = 1'b0;
    #1;
    chk("reenr_mask", voted_mask, 3'b001);
    chk("enr_then_ready", req_ready, 1'b1);
    req("d2_again", D2, 3, 1'b1, 1'b1, 2'd2, 2'd0);
    enroll(2'd3, DX);
    req("oob_miss", DX, 3, 1'b0, 1'b0, 2'd0, 2'd1);
    chk("oob_mask", voted_mask, 3'b101);
    clear_voted = 1'b1;
    step();
    clear_voted = 1'b0;
    chk("clr_mask", voted_mask, 3'b000);
    enroll(2'd0, D0);
    req("d0_pre", D0, 1, 1'b1, 1'b1, 2'd0, 2'd0);
    req_valid = 1'b1; req_digest = D0;
    step();
    req_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("scan_rst", {resp_valid, success, access, voter_idx, locked, fail_count, voted_mask, req_ready}, '0);
    @(negedge clk) rst = 1'b0;
    step();
    req("post_rst", D0, 3, 1'b0, 1'b0, 2'd0, 2'd1);
    req("pr_m2", DX, 3, 1'b0, 1'b0, 2'd0, 2'd2);
    req("pr_m3", DX, 3, 1'b0, 1'b0, 2'd0, 2'd3);
    step();
    chk("lock2_on", locked, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("lock_rst", {resp_valid, success, access, voter_idx, locked, fail_count, voted_mask, req_ready}, '0);
    @(negedge clk) rst = 1'b0;
    step();
    chk("lock_rst_ready", req_ready, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
